// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, read-return owner tags,
// and the width of the anti-starvation hold counter.
package dmem_arb_pkg;
    localparam int HOLD_W = 4;

    typedef enum logic {ARB, LOCK} arb_state_t;
    typedef enum logic {OWN_C, OWN_L} owner_t;
endpackage

// File: rtl/dmem_arb_rtrack.sv
// Read-return tracker: remembers which port issued last cycle's read and
// steers the synchronous memory's read data to that port only.
module dmem_arb_rtrack
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_issue,
    input  logic              rd_owner,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata
);

    logic   rd_pend;
    owner_t owner;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend <= 1'b0;
            owner   <= OWN_C;
        end else begin
            rd_pend <= rd_issue;
            owner   <= owner_t'(rd_owner);
        end
    end

    // Non-owner sees zero so the unused return bus stays quiet.
    always_comb begin
        c_rvalid = rd_pend & (owner == OWN_C);
        l_rvalid = rd_pend & (owner == OWN_L);
        c_rdata  = c_rvalid ? mem_rdata : '0;
        l_rdata  = l_rvalid ? mem_rdata : '0;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port dmem arbiter: CPU port C has fixed priority, loader port L is
// guaranteed service and may lock memory. Optional stats via DMEM_ARB_STATS_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_stall,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    input  logic              l_lock,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
`ifdef DMEM_ARB_STATS_EN
    output logic [31:0]       stat_c_stall_cnt,
    output logic [31:0]       stat_l_gnt_cnt,
`endif
    output logic              locked
);

    localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);

    arb_state_t        state, state_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic              c_win, l_win;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ARB;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    // Grants are gated by reset so every output reads 0 while it is held.
    always_comb begin
        c_win     = 1'b0;
        l_win     = 1'b0;
        state_nxt = state;
        hold_nxt  = hold_cnt;
        if (!reset) begin
            case (state)
                ARB: begin
                    l_win = l_req & (~c_req | (hold_cnt == MAX_HOLD_C));
                    c_win = c_req & ~l_win;
                    if (l_win | ~l_req)
                        hold_nxt = '0;
                    else if (c_win && hold_cnt != MAX_HOLD_C)
                        hold_nxt = hold_cnt + 1'b1;
                    if (l_win & l_lock)
                        state_nxt = LOCK;
                end
                LOCK: begin
                    l_win    = l_req;
                    hold_nxt = '0;
                    if (!l_lock)
                        state_nxt = ARB;
                end
                default: state_nxt = ARB;
            endcase
        end
    end

    always_comb begin
        c_gnt     = c_win;
        l_gnt     = l_win;
        c_stall   = c_req & ~c_win & ~reset;
        locked    = (state == LOCK);
        mem_en    = c_win | l_win;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (c_win) begin
            mem_we    = c_we;
            mem_addr  = c_addr;
            mem_wdata = c_wdata;
        end else if (l_win) begin
            mem_we    = l_we;
            mem_addr  = l_addr;
            mem_wdata = l_wdata;
        end
    end

    dmem_arb_rtrack #(.DATA_W(DATA_W)) u_rtrack (
        .clk       (clk),
        .reset     (reset),
        .rd_issue  (mem_en & ~mem_we),
        .rd_owner  (l_win),
        .mem_rdata (mem_rdata),
        .c_rvalid  (c_rvalid),
        .c_rdata   (c_rdata),
        .l_rvalid  (l_rvalid),
        .l_rdata   (l_rdata)
    );

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_c_stall_cnt <= '0;
            stat_l_gnt_cnt   <= '0;
        end else begin
            if (c_stall) stat_c_stall_cnt <= stat_c_stall_cnt + 32'd1;
            if (l_gnt)   stat_l_gnt_cnt   <= stat_l_gnt_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural synchronous memory.
// Define DMEM_ARB_STATS_EN to also check the statistics counters.
module tb_dmem_arbiter;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              c_req, c_we, c_gnt, c_stall, c_rvalid;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata, c_rdata;
    logic              l_req, l_we, l_lock, l_gnt, l_rvalid;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata, l_rdata;
    logic              mem_en, mem_we, locked;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0]       stat_c_stall_cnt, stat_l_gnt_cnt;
`endif

    int n_err = 0;
    int n_chk = 0;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always #5 clk = ~clk;

    always @(posedge clk)
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(4)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_lock(l_lock), .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
`ifdef DMEM_ARB_STATS_EN
        .stat_c_stall_cnt(stat_c_stall_cnt), .stat_l_gnt_cnt(stat_l_gnt_cnt),
`endif
        .locked(locked)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; checks happen at +4.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
        l_req = 0; l_we = 0; l_addr = '0; l_wdata = '0; l_lock = 0;
    endtask

    task automatic c_drive(input logic we, input int addr, input int data);
        c_req = 1; c_we = we; c_addr = ADDR_W'(addr); c_wdata = DATA_W'(data);
    endtask

    task automatic l_drive(input logic we, input int addr, input int data, input logic lk);
        l_req = 1; l_we = we; l_addr = ADDR_W'(addr); l_wdata = DATA_W'(data); l_lock = lk;
    endtask

    initial begin
        int wd [4];
        wd = '{45, 20, 70, 5};
        for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = '0;
        mem[10] = 30;
        mem[1]  = 32'h77;
        mem_rdata = '0;

        // Reset state: requests present but everything held at 0
        idle();
        reset = 1;
        c_drive(0, 10, 0);
        l_drive(0, 1, 0, 1);
        tick(); #3;
        chk("rst_c_gnt", c_gnt, 0);
        chk("rst_l_gnt", l_gnt, 0);
        chk("rst_c_stall", c_stall, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_locked", locked, 0);
        chk("rst_rvalid", {c_rvalid, l_rvalid}, 0);
        idle();
        tick();
        reset = 0;

        // Anti-starvation: 4 C grants, then L once, then C again
        for (int i = 0; i < 6; i++) begin
            c_drive(0, 0, 0);
            if (i < 5) l_drive(0, 1, 0, 0);
            else       l_req = 0;
            #3;
            chk($sformatf("hold_c_gnt%0d", i), c_gnt, (i != 4));
            chk($sformatf("hold_l_gnt%0d", i), l_gnt, (i == 4));
            chk($sformatf("hold_stall%0d", i), c_stall, (i == 4));
            if (i == 5) begin
                chk("hold_l_rvalid", l_rvalid, 1);
                chk("hold_l_rdata", l_rdata, 32'h77);
                chk("hold_c_rvalid", c_rvalid, 0);
            end
            tick();
        end
        idle();
        #3;
`ifdef DMEM_ARB_STATS_EN
        chk("stat_c_stall", stat_c_stall_cnt, 1);
        chk("stat_l_gnt", stat_l_gnt_cnt, 1);
`endif
        tick();

        // C read addr 10, no L contention
        c_drive(0, 10, 0);
        #3;
        chk("rd_c_gnt", c_gnt, 1);
        chk("rd_mem_addr", mem_addr, 10);
        chk("rd_c_stall", c_stall, 0);
        tick();
        idle();
        #3;
        chk("rd_c_rvalid", c_rvalid, 1);
        chk("rd_c_rdata", c_rdata, 30);
        chk("rd_l_rdata", l_rdata, 0);
        tick();

        // l_lock without l_req is ignored in ARB
        c_drive(0, 10, 0);
        l_lock = 1;
        #3;
        chk("nolock_c_gnt", c_gnt, 1);
        tick();
        idle();
        #3;
        chk("nolock_locked", locked, 0);
        tick();

        // Locked burst write mem[50..53] while C keeps requesting
        for (int i = 0; i < 4; i++) begin
            l_drive(1, 50 + i, wd[i], 1);
            if (i > 0) c_drive(0, 52, 0);
            #3;
            chk($sformatf("lk_l_gnt%0d", i), l_gnt, 1);
            chk($sformatf("lk_c_gnt%0d", i), c_gnt, 0);
            chk($sformatf("lk_wdata%0d", i), mem_wdata, wd[i]);
            if (i > 0) begin
                chk($sformatf("lk_locked%0d", i), locked, 1);
                chk($sformatf("lk_stall%0d", i), c_stall, 1);
            end
            tick();
        end
        l_req = 0; l_lock = 0; l_we = 0;
        #3;
        chk("lk_rel_locked", locked, 1);
        chk("lk_rel_stall", c_stall, 1);
        chk("lk_rel_c_gnt", c_gnt, 0);
        tick(); #3;
        chk("unlk_locked", locked, 0);
        chk("unlk_c_gnt", c_gnt, 1);
        tick();
        idle();
        #3;
        chk("unlk_c_rvalid", c_rvalid, 1);
        chk("unlk_c_rdata", c_rdata, 70);
        tick();

        // C write then L read of the same address, no forwarding
        c_drive(1, 12, 11);
        #3;
        chk("wr_mem_we", mem_we, 1);
        tick();
        idle();
        l_drive(0, 12, 0, 0);
        #3;
        chk("wr_l_gnt", l_gnt, 1);
        tick();
        idle();
        #3;
        chk("wr_l_rvalid", l_rvalid, 1);
        chk("wr_l_rdata", l_rdata, 11);
        chk("wr_c_rvalid", c_rvalid, 0);
        chk("wr_c_rdata", c_rdata, 0);
        tick();

        // Reset in the L read grant cycle drops the return
        l_drive(0, 10, 0, 0);
        #3;
        chk("rr_l_gnt", l_gnt, 1);
        #2;
        reset = 1;
        #1;
        chk("rr_l_gnt_rst", l_gnt, 0);
        tick();
        idle();
        #3;
        chk("rr_l_rvalid0", l_rvalid, 0);
        chk("rr_mem_en", mem_en, 0);
        tick();
        reset = 0;
        #3;
        chk("rr_l_rvalid1", l_rvalid, 0);
        tick();
        c_drive(0, 10, 0);
        #3;
        chk("rr_c_gnt", c_gnt, 1);
        tick();
        idle();
        #3;
        chk("rr_c_rvalid", c_rvalid, 1);
        chk("rr_c_rdata", c_rdata, 30);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
